// File: rtl/alsu_cmd_feeder.sv
`default_nettype none
// ============================================================================
// alsu_cmd_feeder: buffers packed ALSU commands and issues each one on
// registered ALSU pins for repeat+1 cycles, flagging ALSU-invalid commands.
// Revision: 1.0
// ============================================================================
module alsu_cmd_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_data,
  input  logic [2:0]                cmd_repeat,
  input  logic                      flush,
  output logic signed [2:0]         A,
  output logic signed [2:0]         B,
  output logic [2:0]                opcode,
  output logic                      cin,
  output logic                      serial_in,
  output logic                      red_op_A,
  output logic                      red_op_B,
  output logic                      bypass_A,
  output logic                      bypass_B,
  output logic                      direction,
  output logic                      issue_valid,
  output logic                      issue_invalid,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          issue_cnt,
  output logic [CNT_W-1:0]          invalid_cnt
);

  localparam int             c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_rem;
  logic [18:0]       r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [18:0]       w_head;
  logic [2:0]        w_head_op;
  logic              w_head_invalid;

  assign w_full    = (fifo_count == c_full);
  assign w_empty   = (fifo_count == '0);
  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;

  // A new head is taken whenever the issuer has no cycles left on the current one.
  assign w_pop     = !flush && !w_empty && ((r_state == S_IDLE) || (r_rem == 3'd0));

  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_op      = w_head[15:13];
  assign w_head_invalid = (w_head_op[2] && w_head_op[1]) ||
                          ((w_head[4] || w_head[3]) && (w_head_op > 3'd1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_repeat, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   fifo_count <= fifo_count + (c_aw + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (c_aw + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state       <= S_IDLE;
      r_rem         <= 3'd0;
      issue_valid   <= 1'b0;
      issue_invalid <= 1'b0;
      {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
       bypass_A, bypass_B, direction} <= '0;
    end else if (w_pop) begin
      r_state       <= S_ISSUE;
      r_rem         <= w_head[18:16];
      issue_valid   <= 1'b1;
      issue_invalid <= w_head_invalid;
      {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
       bypass_A, bypass_B, direction} <= w_head[15:0];
    end else if (r_rem != 3'd0) begin
      r_rem <= r_rem - 3'd1;
    end else begin
      r_state       <= S_IDLE;
      issue_valid   <= 1'b0;
      issue_invalid <= 1'b0;
      {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
       bypass_A, bypass_B, direction} <= '0;
    end
  end

  // A flush edge leaves both counters untouched, even for the cycle it cuts short.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt   <= '0;
      invalid_cnt <= '0;
    end else if (issue_valid && !flush) begin
      if (issue_cnt != '1) issue_cnt <= issue_cnt + CNT_W'(1);
      if (issue_invalid && (invalid_cnt != '1)) invalid_cnt <= invalid_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
